// File: rtl/seg_vote_accumulator.sv
// Per-slot classifier vote accumulator feeding the VGA plate renderer.
// Latency: frame_end sampled at edge N -> seg*count / counts_valid update at edge N+2.
// Backpressure: none; every input is consumed or ignored in its cycle, outputs hold between windows.
//
// Ports:
//   dclk                 rising-edge clock for all state
//   clr                  synchronous active-high reset, overrides all other inputs
//   frame_start          1-cycle pulse, opens (or restarts) a capture window
//   frame_end            1-cycle pulse, closes the capture window (wins over frame_start)
//   match_valid          classifier result valid this cycle
//   match_slot[2:0]      character slot of the result, 0-5 used, 6-7 dropped
//   match_hit            result voted for the alternate glyph
//   seg1count..seg6count latched 5-bit hit counts for slots 0..5
//   counts_valid         1-cycle pulse when the seg*count outputs have just been refreshed
//   busy                 high while a capture window is open (state ACCUM)
module seg_vote_accumulator #(
  parameter int MIN_SAMPLES = 8,
  parameter int HIT_MAX     = 31,
  parameter int SAMPLE_MAX  = 63
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       match_valid,
  input  logic [2:0] match_slot,
  input  logic       match_hit,
  output logic [4:0] seg1count,
  output logic [4:0] seg2count,
  output logic [4:0] seg3count,
  output logic [4:0] seg4count,
  output logic [4:0] seg5count,
  output logic [4:0] seg6count,
  output logic       counts_valid,
  output logic       busy
);

  localparam int NSLOT = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [4:0] HIT_SAT = 5'(HIT_MAX);
  localparam logic [5:0] SMP_SAT = 6'(SAMPLE_MAX);
  localparam logic [5:0] SMP_MIN = 6'(MIN_SAMPLES);

  logic [1:0] state_q, state_d;
  logic [4:0] hit_q [NSLOT];
  logic [4:0] hit_d [NSLOT];
  logic [5:0] smp_q [NSLOT];
  logic [5:0] smp_d [NSLOT];
  logic [4:0] seg_q [NSLOT];
  logic       latch_go_q;
  logic       counts_valid_q;
  logic       busy_q;

  logic       count_en;
  logic       clear_all;

  always_comb begin
    state_d   = state_q;
    count_en  = 1'b0;
    clear_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_ACCUM;
          clear_all = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (frame_end) begin
          // Closing beats restarting; the match of this cycle still counts.
          state_d  = ST_LATCH;
          count_en = 1'b1;
        end else if (frame_start) begin
          // Restart: fresh window, same-cycle match is dropped.
          clear_all = 1'b1;
        end else begin
          count_en = 1'b1;
        end
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      hit_d[k] = hit_q[k];
      smp_d[k] = smp_q[k];
      if (clear_all) begin
        hit_d[k] = '0;
        smp_d[k] = '0;
      end else if (count_en && match_valid && (match_slot == 3'(k))) begin
        // Saturate rather than wrap so a long window never reads as a small count.
        if (smp_q[k] < SMP_SAT) smp_d[k] = smp_q[k] + 6'd1;
        if (match_hit && (hit_q[k] < HIT_SAT)) hit_d[k] = hit_q[k] + 5'd1;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      latch_go_q     <= 1'b0;
      counts_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        hit_q[k] <= '0;
        smp_q[k] <= '0;
        seg_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      busy_q         <= (state_d == ST_ACCUM);
      // The LATCH cycle arms the update; outputs move one edge later so the
      // refresh lands two edges after frame_end, together with counts_valid.
      latch_go_q     <= (state_q == ST_LATCH);
      counts_valid_q <= latch_go_q;
      for (int k = 0; k < NSLOT; k++) begin
        hit_q[k] <= hit_d[k];
        smp_q[k] <= smp_d[k];
        // Accumulators are untouched until the next frame_start, which can at
        // the earliest clear them at this same edge, so the old values are read.
        if (latch_go_q && (smp_q[k] >= SMP_MIN)) seg_q[k] <= hit_q[k];
      end
    end
  end

  assign seg1count    = seg_q[0];
  assign seg2count    = seg_q[1];
  assign seg3count    = seg_q[2];
  assign seg4count    = seg_q[3];
  assign seg5count    = seg_q[4];
  assign seg6count    = seg_q[5];
  assign counts_valid = counts_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seg_vote_accumulator.sv
// Directed bench for seg_vote_accumulator.
// Latency checked: frame_end edge N -> outputs and counts_valid at edge N+2.
// Inputs driven and outputs sampled on the falling edge of dclk.
module tb_seg_vote_accumulator;

  logic       dclk;
  logic       clr;
  logic       frame_start;
  logic       frame_end;
  logic       match_valid;
  logic [2:0] match_slot;
  logic       match_hit;
  logic [4:0] seg1count, seg2count, seg3count, seg4count, seg5count, seg6count;
  logic       counts_valid;
  logic       busy;

  logic [4:0] seg_w [6];
  assign seg_w[0] = seg1count;
  assign seg_w[1] = seg2count;
  assign seg_w[2] = seg3count;
  assign seg_w[3] = seg4count;
  assign seg_w[4] = seg5count;
  assign seg_w[5] = seg6count;

  int vectors;
  int miscompares;

  logic [4:0] exp_seg  [6];
  logic [4:0] obs_pre  [6];
  logic [4:0] obs_post [6];
  logic       obs_cv_n0, obs_cv_n1, obs_cv_n2, obs_cv_n3;
  logic       obs_busy_n0, obs_busy_n1, obs_busy_n2;

  seg_vote_accumulator #(
    .MIN_SAMPLES(8),
    .HIT_MAX    (31),
    .SAMPLE_MAX (63)
  ) dut (
    .dclk        (dclk),
    .clr         (clr),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .match_valid (match_valid),
    .match_slot  (match_slot),
    .match_hit   (match_hit),
    .seg1count   (seg1count),
    .seg2count   (seg2count),
    .seg3count   (seg3count),
    .seg4count   (seg4count),
    .seg5count   (seg5count),
    .seg6count   (seg6count),
    .counts_valid(counts_valid),
    .busy        (busy)
  );

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  // ---------------- stimulus helpers (drive only, no checking) ----------------

  task automatic open_window();
    frame_start = 1'b1;
    @(negedge dclk);
    frame_start = 1'b0;
  endtask

  task automatic samples(input logic [2:0] sl, input logic ht, input int n);
    for (int i = 0; i < n; i++) begin
      match_valid = 1'b1;
      match_slot  = sl;
      match_hit   = ht;
      @(negedge dclk);
    end
    match_valid = 1'b0;
    match_hit   = 1'b0;
    match_slot  = 3'd0;
  endtask

  // Pulses frame_end (optionally with a match and/or frame_start) and records
  // what the outputs look like after edges N, N+1, N+2, N+3.
  task automatic close_window(input logic mv, input logic [2:0] sl, input logic ht,
                              input logic fs_too, input logic fs_in_latch);
    frame_end   = 1'b1;
    frame_start = fs_too;
    match_valid = mv;
    match_slot  = sl;
    match_hit   = ht;
    @(negedge dclk);
    frame_end   = 1'b0;
    frame_start = fs_in_latch;
    match_valid = 1'b0;
    match_hit   = 1'b0;
    match_slot  = 3'd0;
    obs_cv_n0   = counts_valid;
    obs_busy_n0 = busy;
    @(negedge dclk);
    frame_start = 1'b0;
    obs_cv_n1   = counts_valid;
    obs_busy_n1 = busy;
    for (int k = 0; k < 6; k++) obs_pre[k] = seg_w[k];
    @(negedge dclk);
    obs_cv_n2   = counts_valid;
    obs_busy_n2 = busy;
    for (int k = 0; k < 6; k++) obs_post[k] = seg_w[k];
    @(negedge dclk);
    obs_cv_n3   = counts_valid;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    clr         = 1'b1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    match_valid = 1'b0;
    match_slot  = 3'd0;
    match_hit   = 1'b0;
    repeat (2) @(negedge dclk);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (seg_w[k] !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_init seg%0d: got %0d want 0", k + 1, seg_w[k]);
      end
    end
    vectors++;
    if ({busy, counts_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_init busy/cv: got %b want 00", {busy, counts_valid});
    end
    clr = 1'b0;
    @(negedge dclk);

    open_window();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy_accum: got %b want 1", busy);
    end
    samples(3'd0, 1'b1, 5);
    clr = 1'b1;
    repeat (2) @(negedge dclk);
    clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (seg_w[k] !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_mid seg%0d: got %0d want 0", k + 1, seg_w[k]);
      end
    end
    vectors++;
    if ({busy, counts_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid busy/cv: got %b want 00", {busy, counts_valid});
    end
    // frame_end while IDLE must not start a latch.
    frame_end = 1'b1;
    @(negedge dclk);
    frame_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({busy, counts_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_lone_end cyc%0d busy/cv: got %b want 00", i, {busy, counts_valid});
      end
      @(negedge dclk);
    end
    for (int k = 0; k < 6; k++) exp_seg[k] = 5'd0;
  endtask

  task automatic test_basic();
    open_window();
    samples(3'd0, 1'b1, 10);
    samples(3'd0, 1'b0, 2);
    samples(3'd3, 1'b1, 2);
    samples(3'd3, 1'b0, 7);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[0] = 5'd10;
    exp_seg[3] = 5'd2;
    vectors++;
    if ({obs_cv_n0, obs_cv_n1, obs_cv_n2, obs_cv_n3} !== 4'b0010) begin
      miscompares++;
      $display("FAIL basic cv_pulse N..N+3: got %b want 0010",
               {obs_cv_n0, obs_cv_n1, obs_cv_n2, obs_cv_n3});
    end
    vectors++;
    if (obs_pre[0] !== 5'd0) begin
      miscompares++;
      $display("FAIL basic early_update seg1 at N+1: got %0d want 0", obs_pre[0]);
    end
    vectors++;
    if (obs_busy_n0 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic busy_in_latch: got %b want 0", obs_busy_n0);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs_post[k] !== exp_seg[k]) begin
        miscompares++;
        $display("FAIL basic seg%0d: got %0d want %0d", k + 1, obs_post[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_saturation();
    open_window();
    samples(3'd5, 1'b1, 40);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[5] = 5'd31;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs_post[k] !== exp_seg[k]) begin
        miscompares++;
        $display("FAIL sat_hits seg%0d: got %0d want %0d", k + 1, obs_post[k], exp_seg[k]);
      end
    end
    open_window();
    samples(3'd5, 1'b0, 70);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[5] = 5'd0;
    vectors++;
    if (obs_post[5] !== exp_seg[5]) begin
      miscompares++;
      $display("FAIL sat_samples seg6: got %0d want %0d", obs_post[5], exp_seg[5]);
    end
    vectors++;
    if (obs_cv_n2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_samples cv: got %b want 1", obs_cv_n2);
    end
  endtask

  task automatic test_min_samples();
    open_window();
    samples(3'd1, 1'b1, 10);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[1] = 5'd10;
    vectors++;
    if (obs_post[1] !== exp_seg[1]) begin
      miscompares++;
      $display("FAIL min_win1 seg2: got %0d want %0d", obs_post[1], exp_seg[1]);
    end
    open_window();
    samples(3'd1, 1'b1, 7);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs_post[1] !== exp_seg[1]) begin
      miscompares++;
      $display("FAIL min_below seg2: got %0d want %0d", obs_post[1], exp_seg[1]);
    end
    vectors++;
    if (obs_cv_n2 !== 1'b1) begin
      miscompares++;
      $display("FAIL min_below cv: got %b want 1", obs_cv_n2);
    end
    // Exactly MIN_SAMPLES samples is enough.
    open_window();
    samples(3'd1, 1'b1, 8);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[1] = 5'd8;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs_post[k] !== exp_seg[k]) begin
        miscompares++;
        $display("FAIL min_exact seg%0d: got %0d want %0d", k + 1, obs_post[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_invalid_and_simul();
    open_window();
    samples(3'd6, 1'b1, 20);
    samples(3'd7, 1'b1, 20);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs_post[k] !== exp_seg[k]) begin
        miscompares++;
        $display("FAIL invalid_slot seg%0d: got %0d want %0d", k + 1, obs_post[k], exp_seg[k]);
      end
    end
    open_window();
    samples(3'd2, 1'b1, 8);
    close_window(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    exp_seg[2] = 5'd9;
    vectors++;
    if (obs_post[2] !== exp_seg[2]) begin
      miscompares++;
      $display("FAIL simul_end seg3: got %0d want %0d", obs_post[2], exp_seg[2]);
    end
  endtask

  task automatic test_restart();
    open_window();
    samples(3'd0, 1'b1, 6);
    // Restart with a same-cycle hit that must be discarded.
    frame_start = 1'b1;
    match_valid = 1'b1;
    match_slot  = 3'd0;
    match_hit   = 1'b1;
    @(negedge dclk);
    frame_start = 1'b0;
    match_valid = 1'b0;
    match_hit   = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart busy: got %b want 1", busy);
    end
    samples(3'd0, 1'b1, 9);
    close_window(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_seg[0] = 5'd9;
    vectors++;
    if (obs_post[0] !== exp_seg[0]) begin
      miscompares++;
      $display("FAIL restart seg1: got %0d want %0d", obs_post[0], exp_seg[0]);
    end
  endtask

  task automatic test_back_to_back();
    // frame_start with frame_end latches; frame_start during LATCH is ignored.
    open_window();
    samples(3'd4, 1'b1, 8);
    close_window(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    exp_seg[4] = 5'd8;
    vectors++;
    if ({obs_busy_n0, obs_busy_n1, obs_busy_n2} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b busy N..N+2: got %b want 000", {obs_busy_n0, obs_busy_n1, obs_busy_n2});
    end
    vectors++;
    if ({obs_cv_n0, obs_cv_n1, obs_cv_n2, obs_cv_n3} !== 4'b0010) begin
      miscompares++;
      $display("FAIL b2b cv_pulse N..N+3: got %b want 0010",
               {obs_cv_n0, obs_cv_n1, obs_cv_n2, obs_cv_n3});
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (obs_post[k] !== exp_seg[k]) begin
        miscompares++;
        $display("FAIL b2b seg%0d: got %0d want %0d", k + 1, obs_post[k], exp_seg[k]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    match_valid = 1'b0;
    match_slot  = 3'd0;
    match_hit   = 1'b0;
    @(negedge dclk);
    test_reset();
    test_basic();
    test_saturation();
    test_min_samples();
    test_invalid_and_simul();
    test_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_vote_accumulator.md
Name: seg_vote_accumulator

Overview:
- Sits directly upstream of the 640x480 VGA renderer and produces its six 5-bit per-character vote counts.
- During a capture window it accumulates classifier results per plate character slot (0-5).
- At window end it latches a saturating hit count per slot onto outputs that the renderer compares against its glyph threshold.
- Holds outputs stable between windows so the display never tears mid-frame.

Parameters:
- MIN_SAMPLES, 8: minimum classifier samples a slot must receive in a window for its output to update. Range 1-63.
- HIT_MAX, 31: saturation value of the per-slot hit counter. Must be ≤ 31.
- SAMPLE_MAX, 63: saturation value of the per-slot sample counter. Width 6 bits.

Ports:
- dclk  in  1  system/pixel clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- frame_start  in  1  single-cycle pulse; opens a capture window.
- frame_end  in  1  single-cycle pulse; closes the capture window.
- match_valid  in  1  classifier result valid this cycle.
- match_slot  in  3  character slot of the result. Values 0-5 valid; 6-7 are ignored.
- match_hit  in  1  1 = sample voted for the alternate glyph (counts toward hit total).
- seg1count … seg6count  out  5 each  latched hit counts for slots 0…5, registered.
- counts_valid  out  1  one-cycle pulse when the seg*count outputs have just updated.
- busy  out  1  high while state = ACCUM.

Behaviour:
- One clock, dclk. Reset is synchronous and active-high on clr.
- Reset values while clr is sampled high:
  - state = IDLE.
  - All seg*count = 0.
  - All hit and sample accumulators = 0.
  - counts_valid = 0, busy = 0.
- clr overrides every other input in the same cycle, including mid-window.
- FSM states: IDLE, ACCUM, LATCH.
- IDLE:
  - frame_start → ACCUM; all 6 hit and 6 sample accumulators cleared at that edge.
  - frame_end and match_valid are ignored.
- ACCUM:
  - Each cycle with match_valid=1 and match_slot≤5: that slot's sample counter increments, saturating at SAMPLE_MAX.
  - If match_hit=1 as well, that slot's hit counter increments, saturating at HIT_MAX.
  - Counters never wrap.
- Boundary cases in ACCUM:
  - match_slot 6-7: no counter changes.
  - frame_end → LATCH. A match sampled in the same cycle as frame_end is still counted.
  - frame_start without frame_end: restart. All accumulators are cleared and the same-cycle match is discarded; state stays ACCUM.
  - frame_start and frame_end together: frame_end has priority and frame_start is ignored.
- LATCH (exactly one cycle):
  - For each slot with sample count ≥ MIN_SAMPLES: seg(k+1)count ← hit count.
  - Every other slot holds its previous output.
  - counts_valid = 1 in the cycle after the LATCH edge (registered), 0 otherwise.
  - Inputs in the LATCH cycle are ignored, including frame_start.
  - Next state is IDLE.
- Latency: frame_end sampled at edge N → outputs and counts_valid change at edge N+2.
- busy is a registered decode of state; it is 1 exactly while state = ACCUM.
- Outputs change only at the LATCH update or under clr.

Test Plan:
- Reset: assert clr 2 cycles mid-ACCUM with slot 0 holding 5 hits → all seg*count=0, busy=0, counts_valid=0; a following frame_end alone yields no counts_valid.
- Basic count: frame_start; slot 0 gets 12 samples (10 hits); slot 3 gets 9 samples (2 hits); frame_end → 2 cycles later seg1count=10, seg4count=2, others 0, counts_valid high for 1 cycle.
- Saturation: 40 hit samples to slot 5 in one window → seg6count=31; 70 samples with 0 hits → seg6count=0.
- MIN_SAMPLES gate: window 1 gives slot 1 ten hits (seg2count=10); window 2 gives slot 1 only 7 samples, all hits → seg2count remains 10.
- Invalid slot and simultaneity: 20 hits with match_slot=6 → no output change. A hit on slot 2 coincident with frame_end is counted: 8 prior hits → seg3count=9.
- Restart: 6 hits to slot 0, then frame_start, then 9 hits and frame_end → seg1count=9. frame_start and frame_end together → latch occurs and state returns to IDLE.
